// File: rtl/tx_axis_pkg.sv
// Shared widths, stat counter sizes and frame-tracker state for the TX AXI-Stream output stage.
package tx_axis_pkg;

    localparam int DEF_DATA_W    = 512;
    localparam int DEF_ID_W      = 10;
    localparam int DEF_DEST_W    = 4;
    localparam int DEF_USER_W    = 232;

    localparam int STAT_FRAMES_W = 32;
    localparam int STAT_BYTES_W  = 48;

    typedef enum logic {
        IDLE,
        IN_PKT
    } trk_state_t;

endpackage

// File: rtl/tx_axis_keep_popcount.sv
// Counts the set bits of a tkeep vector; purely combinational, no backpressure involvement.
module tx_axis_keep_popcount #(
    parameter  int KEEP_W = 64,
    localparam int CNT_W  = $clog2(KEEP_W) + 1
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            count = count + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/tx_axis_out_fifo.sv
// Registered-output AXIS FIFO after the TX mux: 1-cycle latency, s_axis_tready drops only when full.
// Flags cross-source interleaving inside a frame; TX_AXIS_OUT_FIFO_STATS_EN adds frame/byte counters.
module tx_axis_out_fifo
    import tx_axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH    = DEF_DATA_W,
    parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_TX_ID_WIDTH   = DEF_ID_W,
    parameter int AXIS_TX_DEST_WIDTH = DEF_DEST_W,
    parameter int AXIS_TX_USER_WIDTH = DEF_USER_W,
    parameter int DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    input  logic [AXIS_TX_ID_WIDTH-1:0]   s_axis_tid,
    input  logic [AXIS_TX_DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [AXIS_TX_USER_WIDTH-1:0] s_axis_tuser,
    output logic                          s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [AXIS_TX_ID_WIDTH-1:0]   m_axis_tid,
    output logic [AXIS_TX_DEST_WIDTH-1:0] m_axis_tdest,
    output logic [AXIS_TX_USER_WIDTH-1:0] m_axis_tuser,
    input  logic                          m_axis_tready,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          interleave_err
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
    ,
    output logic [STAT_FRAMES_W-1:0]      stat_frames,
    output logic [STAT_BYTES_W-1:0]       stat_bytes
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1 + AXIS_TX_ID_WIDTH
                      + AXIS_TX_DEST_WIDTH + AXIS_TX_USER_WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] s_entry;
    logic [EW-1:0] out_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign s_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty         = (wr_ptr == rd_ptr);
    assign s_axis_tready = !full && !rst;
    assign m_axis_tvalid = !empty;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign rd_next       = rd_ptr + PW'(pop);
    assign occupancy     = wr_ptr - rd_ptr;

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_entry;
        end
    end

    // out_q always mirrors the head entry; a beat written straight into the head slot bypasses mem
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            out_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && (wr_ptr == rd_next)) begin
                out_q <= s_entry;
            end else if (pop) begin
                out_q <= mem[rd_next[AW-1:0]];
            end
        end
    end

    trk_state_t                    state_q;
    trk_state_t                    state_d;
    logic [AXIS_TX_ID_WIDTH-1:0]   cap_id_q;
    logic [AXIS_TX_DEST_WIDTH-1:0] cap_dest_q;
    logic                          set_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cap_id_q       <= '0;
            cap_dest_q     <= '0;
            interleave_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push && (state_q == IDLE)) begin
                cap_id_q   <= s_axis_tid;
                cap_dest_q <= s_axis_tdest;
            end
            if (set_err) begin
                interleave_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        if (push) begin
            case (state_q)
                IDLE: begin
                    if (!s_axis_tlast) begin
                        state_d = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if ((s_axis_tid != cap_id_q) || (s_axis_tdest != cap_dest_q)) begin
                        set_err = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef TX_AXIS_OUT_FIFO_STATS_EN
    localparam int CNT_W = $clog2(AXIS_KEEP_WIDTH) + 1;

    logic [CNT_W-1:0] keep_cnt;

    tx_axis_keep_popcount #(
        .KEEP_W (AXIS_KEEP_WIDTH)
    ) u_keep_popcount (
        .keep  (m_axis_tkeep),
        .count (keep_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames <= '0;
            stat_bytes  <= '0;
        end else if (pop) begin
            stat_bytes <= stat_bytes + STAT_BYTES_W'(keep_cnt);
            if (m_axis_tlast) begin
                stat_frames <= stat_frames + STAT_FRAMES_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_axis_out_fifo.sv
// Scoreboard bench for tx_axis_out_fifo: latency, full/backpressure, interleave flag, reset.
module tb_tx_axis_out_fifo;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int IW = 10;
    localparam int TW = 4;
    localparam int UW = 232;
    localparam int PLW = DW + KW + 1 + IW + TW + UW;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [IW-1:0] id;
        logic [TW-1:0] dest;
        logic [UW-1:0] user;
        int            cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [IW-1:0] s_axis_tid = '0;
    logic [TW-1:0] s_axis_tdest = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic [IW-1:0] m_axis_tid;
    logic [TW-1:0] m_axis_tdest;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tready = 1'b0;
    logic [2:0]    occupancy;
    logic          interleave_err;
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
    logic [31:0]   stat_frames;
    logic [47:0]   stat_bytes;
`endif

    tx_axis_out_fifo #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tdest   (s_axis_tdest),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tid     (m_axis_tid),
        .m_axis_tdest   (m_axis_tdest),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tready  (m_axis_tready),
        .occupancy      (occupancy),
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
        .stat_frames    (stat_frames),
        .stat_bytes     (stat_bytes),
`endif
        .interleave_err (interleave_err)
    );

    always #5 clk = ~clk;

    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    out_cnt = 0;
    bit    lat_chk = 1'b0;
    bit    rand_bp = 1'b0;
    bit    hold_pending = 1'b0;
    logic [PLW-1:0] held;
    logic [PLW-1:0] m_payload;
    beat_t sb[$];

    assign m_payload = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 m_axis_tready = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: sample half a cycle before each edge, push accepted inputs, pop and compare outputs
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (!m_axis_tvalid || m_payload !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%0b tid=%0d data[63:0]=%h, expected valid=1 tid=%0d data[63:0]=%h",
                             m_axis_tvalid, m_axis_tid, m_axis_tdata[63:0], held[PLW-DW+IW+TW+UW-1 -: IW], held[PLW-DW +: 64]);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got unexpected beat tid=%0d, expected no beat", m_axis_tid);
                end else begin
                    e = sb.pop_front();
                    if (m_payload !== {e.data, e.keep, e.last, e.id, e.dest, e.user}) begin
                        errors++;
                        $display("FAIL out_beat: got tid=%0d last=%0b keep=%h data[63:0]=%h, expected tid=%0d last=%0b keep=%h data[63:0]=%h",
                                 m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata[63:0], e.id, e.last, e.keep, e.data[63:0]);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc != e.cyc + 1) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected 1", cyc - e.cyc);
                        end
                    end
                end
                out_cnt++;
            end
            hold_pending = m_axis_tvalid && !m_axis_tready;
            held = m_payload;
            if (s_axis_tvalid && s_axis_tready) begin
                e.data = s_axis_tdata; e.keep = s_axis_tkeep; e.last = s_axis_tlast;
                e.id = s_axis_tid; e.dest = s_axis_tdest; e.user = s_axis_tuser; e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Call at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send_beat(input logic [KW-1:0] k, input logic l, input logic [IW-1:0] id, input logic [TW-1:0] dest);
        int n;
        logic [DW-1:0] d;
        d = rnd_data();
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
        s_axis_tid = id; s_axis_tdest = dest; s_axis_tuser = d[UW-1:0] ^ {UW{1'b1}};
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_axis_tready in %0d cycles, expected acceptance", n);
        end
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain: got %0d beats left after %0d cycles, expected 0", sb.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b, expected 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b, expected 0", m_axis_tvalid); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy: got %0d, expected 0", occupancy); end
        if (interleave_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", interleave_err); end
        if (m_axis_tdata !== '0 || m_axis_tid !== '0) begin errors++; $display("FAIL rst_payload: got tid=%0d, expected zero payload", m_axis_tid); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b, expected 1", s_axis_tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        int base;
        base = out_cnt;
        m_axis_tready = 1'b1;
        lat_chk = 1'b1;
        send_beat({KW{1'b1}}, 1'b0, 10'd5, 4'd2);
        send_beat({KW{1'b1}}, 1'b0, 10'd5, 4'd2);
        send_beat(64'h0000_0000_0000_00FF, 1'b1, 10'd5, 4'd2);
        wait_drain();
        lat_chk = 1'b0;
        checks += 2;
        if (out_cnt - base != 3) begin errors++; $display("FAIL single_count: got %0d, expected 3", out_cnt - base); end
        if (interleave_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b, expected 0", interleave_err); end
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
        checks += 2;
        if (stat_frames !== 32'd1) begin errors++; $display("FAIL single_frames: got %0d, expected 1", stat_frames); end
        if (stat_bytes !== 48'd136) begin errors++; $display("FAIL single_bytes: got %0d, expected 136", stat_bytes); end
`endif
    endtask

    task automatic test_full();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat({KW{1'b1}}, i == 3, 10'd20, 4'd1);
        @(negedge clk);
        checks += 2;
        if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d, expected 4", occupancy); end
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", s_axis_tready); end
        @(posedge clk);
        #1;
        s_axis_tdata = rnd_data(); s_axis_tkeep = 64'h0F; s_axis_tlast = 1'b1;
        s_axis_tid = 10'd21; s_axis_tdest = 4'd1; s_axis_tuser = '1; s_axis_tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd4) begin errors++; $display("FAIL full_hold: got occupancy %0d, expected 4", occupancy); end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (occupancy !== 3'd3) begin errors++; $display("FAIL full_pop_no_push: got occupancy %0d, expected 3", occupancy); end
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b, expected 1", s_axis_tready); end
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd4) begin errors++; $display("FAIL full_refill: got occupancy %0d, expected 4", occupancy); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = out_cnt;
        m_axis_tready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 100; i++) send_beat({KW{1'b1}}, 1'b1, IW'(i), TW'(i));
        wait_drain();
        lat_chk = 1'b0;
        checks += 2;
        if (out_cnt - base != 100) begin errors++; $display("FAIL b2b_count: got %0d, expected 100", out_cnt - base); end
        if (interleave_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b, expected 0", interleave_err); end
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
        checks += 2;
        if (stat_frames !== 32'd100) begin errors++; $display("FAIL b2b_frames: got %0d, expected 100", stat_frames); end
        if (stat_bytes !== 48'd6400) begin errors++; $display("FAIL b2b_bytes: got %0d, expected 6400", stat_bytes); end
`endif
    endtask

    task automatic test_interleave();
        m_axis_tready = 1'b1;
        send_beat({KW{1'b1}}, 1'b0, 10'd1, 4'd3);
        checks++;
        if (interleave_err !== 1'b0) begin errors++; $display("FAIL ilv_first: got %b, expected 0", interleave_err); end
        send_beat({KW{1'b1}}, 1'b0, 10'd2, 4'd3);
        checks++;
        if (interleave_err !== 1'b1) begin errors++; $display("FAIL ilv_set: got %b, expected 1", interleave_err); end
        send_beat({KW{1'b1}}, 1'b1, 10'd1, 4'd3);
        wait_drain();
        checks++;
        if (interleave_err !== 1'b1) begin errors++; $display("FAIL ilv_sticky: got %b, expected 1", interleave_err); end
    endtask

    task automatic test_random_bp();
        int base;
        logic [IW-1:0] fid;
        base = out_cnt;
        fid = 10'd100;
        rand_bp = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic l;
            l = ($urandom_range(0, 3) == 0);
            send_beat(KW'({$urandom(), $urandom()}), l, fid, 4'd5);
            if (l) fid = fid + 10'd1;
        end
        rand_bp = 1'b0;
        wait_drain();
        checks++;
        if (out_cnt - base != 1000) begin errors++; $display("FAIL rand_count: got %0d, expected 1000", out_cnt - base); end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat({KW{1'b1}}, 1'b0, 10'd3, 4'd6);
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_occ: got %0d, expected 3", occupancy); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks += 4;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", m_axis_tvalid); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_rst_occ: got %0d, expected 0", occupancy); end
        if (interleave_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b, expected 0", interleave_err); end
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL mid_rst_payload: got data[63:0]=%h, expected 0", m_axis_tdata[63:0]); end
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
        checks++;
        if (stat_frames !== 32'd0 || stat_bytes !== 48'd0) begin
            errors++; $display("FAIL mid_rst_stats: got frames=%0d bytes=%0d, expected 0/0", stat_frames, stat_bytes);
        end
`endif
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_axis_tready = 1'b1;
        send_beat({KW{1'b1}}, 1'b0, 10'd9, 4'd7);
        send_beat(64'h3, 1'b1, 10'd9, 4'd7);
        wait_drain();
        checks++;
        if (interleave_err !== 1'b0) begin errors++; $display("FAIL post_rst_err: got %b, expected 0", interleave_err); end
`ifdef TX_AXIS_OUT_FIFO_STATS_EN
        checks += 2;
        if (stat_frames !== 32'd1) begin errors++; $display("FAIL post_rst_frames: got %0d, expected 1", stat_frames); end
        if (stat_bytes !== 48'd66) begin errors++; $display("FAIL post_rst_bytes: got %0d, expected 66", stat_bytes); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_full();
        test_back_to_back();
        test_interleave();
        test_random_bp();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1000000 time units, expected finish");
        $fatal(1);
    end

endmodule
